// File: rtl/legv8_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle controller.
package legv8_pkg;

    localparam int unsigned OPC_W     = 11;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned IMM_SEL_W = 2;
    localparam int unsigned ALU_OP_W  = 2;
    localparam int unsigned PC_SRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EX_R    = 4'd2,
        S_WB_R    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_WB_LD   = 4'd6,
        S_MEM_WR  = 4'd7,
        S_CB_BR   = 4'd8,
        S_B_BR    = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LD  = 3'd1,
        CLS_ST  = 3'd2,
        CLS_CBZ = 3'd3,
        CLS_B   = 3'd4,
        CLS_ILL = 3'd7
    } cls_e;

    localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]       OP_CBZ8 = 8'b10110100;
    localparam logic [5:0]       OP_B6   = 6'b000101;

    localparam logic [IMM_SEL_W-1:0] IMM_B  = 2'b00;
    localparam logic [IMM_SEL_W-1:0] IMM_CB = 2'b01;
    localparam logic [IMM_SEL_W-1:0] IMM_D  = 2'b10;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT  = 2'b10;

    localparam logic [PC_SRC_W-1:0] PC_SEQ = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_BR  = 2'b01;

endpackage

// File: rtl/legv8_opdecode.sv
// Classifies the 11-bit LEGv8 opcode field into a controller instruction class.
module legv8_opdecode
    import legv8_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output cls_e             cls,
    output logic             illegal
);

    always_comb begin
        cls = CLS_ILL;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
            cls = CLS_R;
        end else if (opcode == OP_LDUR) begin
            cls = CLS_LD;
        end else if (opcode == OP_STUR) begin
            cls = CLS_ST;
        end else if (opcode[10:3] == OP_CBZ8) begin
            cls = CLS_CBZ;
        end else if (opcode[10:5] == OP_B6) begin
            cls = CLS_B;
        end
        illegal = (cls == CLS_ILL);
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_rd,
    output logic                 dmem_wr,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [PC_SRC_W-1:0]  pc_src,
    output logic [IMM_SEL_W-1:0] imm_sel,
    output logic                 reg2loc,
    output logic                 alu_src,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 illegal_op,
    output logic [CNT_W-1:0]     retired,
    output logic [STATE_W-1:0]   state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic             active_q;
    cls_e             cls;
    logic             cls_illegal;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^instr[20:0];

    legv8_opdecode u_opdecode (
        .opcode  (op_q),
        .cls     (cls),
        .illegal (cls_illegal)
    );

    // active_q holds every output quiet until the first cycle after reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            op_q      <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            op_q      <= op_d;
            active_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        retired_d  = retired_q;
        op_d       = op_q;
        imem_req   = 1'b0;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        imm_sel    = IMM_B;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;

        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        op_d     = instr[31:21];
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (cls)
                        CLS_R:          state_d = S_EX_R;
                        CLS_LD, CLS_ST: state_d = S_EX_ADDR;
                        CLS_CBZ:        state_d = S_CB_BR;
                        CLS_B:          state_d = S_B_BR;
                        default: begin
                            illegal_op = TRAP_ON_ILLEGAL && cls_illegal;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
                S_EX_R: begin
                    alu_op  = ALU_FUNCT;
                    state_d = S_WB_R;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
                S_EX_ADDR: begin
                    imm_sel = IMM_D;
                    alu_src = 1'b1;
                    reg2loc = 1'b1;
                    state_d = (cls == CLS_LD) ? S_MEM_RD : S_MEM_WR;
                end
                // address controls stay stable for the whole memory access
                S_MEM_RD: begin
                    imm_sel = IMM_D;
                    alu_src = 1'b1;
                    reg2loc = 1'b1;
                    dmem_rd = 1'b1;
                    if (dmem_ready) state_d = S_WB_LD;
                end
                S_WB_LD: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retired_d  = retired_q + CNT_W'(1);
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    imm_sel = IMM_D;
                    alu_src = 1'b1;
                    reg2loc = 1'b1;
                    dmem_wr = 1'b1;
                    if (dmem_ready) begin
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                end
                S_CB_BR: begin
                    reg2loc   = 1'b1;
                    alu_op    = ALU_PASS_B;
                    imm_sel   = IMM_CB;
                    pc_src    = PC_BR;
                    pc_write  = zero;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
                S_B_BR: begin
                    imm_sel   = IMM_B;
                    pc_src    = PC_BR;
                    pc_write  = 1'b1;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Directed-vector bench for legv8_mc_ctrl; expected values are hand-derived per cycle.
module tb_legv8_mc_ctrl;
    import legv8_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, dmem_rd, dmem_wr, ir_write, pc_write;
    logic [1:0]  pc_src, imm_sel, alu_op;
    logic        reg2loc, alu_src, reg_write, mem_to_reg, illegal_op;
    logic [31:0] retired;
    logic [3:0]  state;

    int n_vec;
    int n_err;

    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_LDUR = 32'hF8408020;
    localparam logic [31:0] I_STUR = 32'hF8008020;
    localparam logic [31:0] I_CBZ  = 32'hB4000083;
    localparam logic [31:0] I_B    = 32'h17FFFFFF;
    localparam logic [31:0] I_ILL  = 32'h00000000;

    legv8_mc_ctrl #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .imm_sel    (imm_sel),
        .reg2loc    (reg2loc),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .retired    (retired),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, apply inputs, let combinational outputs settle.
    task automatic cyc(input logic ir, input logic dr, input logic z);
        @(negedge clk);
        imem_ready = ir;
        dmem_ready = dr;
        zero       = z;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        instr = I_ADD;
        zero = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        cyc(0, 0, 0);
        cyc(1, 1, 0);
        check("rst_state", state, S_FETCH);
        check("rst_retired", retired, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_ir_write", ir_write, 0);
        check("rst_pc_write", pc_write, 0);

        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        // ADD, zero-wait: FETCH, DECODE, EX_R, WB_R
        instr = I_ADD;
        cyc(1, 1, 0);
        check("add_c1_state", state, S_FETCH);
        check("add_c1_imem_req", imem_req, 1);
        check("add_c1_ir_write", ir_write, 1);
        check("add_c1_pc_write", pc_write, 1);
        check("add_c1_pc_src", pc_src, 2'b00);
        check("add_c1_dmem_rd", dmem_rd, 0);
        cyc(0, 0, 0);
        check("add_c2_state", state, S_DECODE);
        check("add_c2_imem_req", imem_req, 0);
        cyc(0, 0, 0);
        check("add_c3_state", state, S_EX_R);
        check("add_c3_alu_op", alu_op, 2'b10);
        check("add_c3_alu_src", alu_src, 0);
        cyc(0, 0, 0);
        check("add_c4_state", state, S_WB_R);
        check("add_c4_reg_write", reg_write, 1);
        check("add_c4_mem_to_reg", mem_to_reg, 0);
        check("add_c4_retired", retired, 0);
        cyc(0, 0, 0);
        check("add_done_state", state, S_FETCH);
        check("add_done_retired", retired, 1);

        // LDUR with dmem_ready three cycles late
        instr = I_LDUR;
        check("ldur_c1_ir_write_wait", ir_write, 0);
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        // the previous cyc already consumed FETCH cycle 1 with imem_ready=0; redo cleanly
        check("ldur_c1b_state", state, S_FETCH);
        check("ldur_c1b_ir_write", ir_write, 1);
        cyc(0, 0, 0);
        check("ldur_c2_state", state, S_DECODE);
        cyc(0, 0, 0);
        check("ldur_c3_state", state, S_EX_ADDR);
        check("ldur_c3_imm_sel", imm_sel, 2'b10);
        check("ldur_c3_alu_src", alu_src, 1);
        check("ldur_c3_reg2loc", reg2loc, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, (i == 3), 0);
            check($sformatf("ldur_mem%0d_state", i), state, S_MEM_RD);
            check($sformatf("ldur_mem%0d_dmem_rd", i), dmem_rd, 1);
            check($sformatf("ldur_mem%0d_imm_sel", i), imm_sel, 2'b10);
            check($sformatf("ldur_mem%0d_alu_src", i), alu_src, 1);
        end
        cyc(0, 0, 0);
        check("ldur_wb_state", state, S_WB_LD);
        check("ldur_wb_dmem_rd", dmem_rd, 0);
        check("ldur_wb_mem_to_reg", mem_to_reg, 1);
        check("ldur_wb_reg_write", reg_write, 1);
        cyc(0, 0, 0);
        check("ldur_done_state", state, S_FETCH);
        check("ldur_done_retired", retired, 2);

        // CBZ taken then not taken
        instr = I_CBZ;
        for (int k = 0; k < 2; k++) begin
            logic zv;
            zv = (k == 0);
            check($sformatf("cbz%0d_c1_state", k), state, S_FETCH);
            @(negedge clk);
            imem_ready = 1'b1;
            #1;
            cyc(0, 0, zv);
            check($sformatf("cbz%0d_c2_state", k), state, S_DECODE);
            cyc(0, 0, zv);
            check($sformatf("cbz%0d_c3_state", k), state, S_CB_BR);
            check($sformatf("cbz%0d_c3_pc_write", k), pc_write, zv);
            check($sformatf("cbz%0d_c3_pc_src", k), pc_src, 2'b01);
            check($sformatf("cbz%0d_c3_imm_sel", k), imm_sel, 2'b01);
            check($sformatf("cbz%0d_c3_alu_op", k), alu_op, 2'b01);
            check($sformatf("cbz%0d_c3_reg2loc", k), reg2loc, 1);
            cyc(0, 0, 0);
            check($sformatf("cbz%0d_retired", k), retired, 3 + k);
        end

        // B: three cycles
        instr = I_B;
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        check("b_c1_state", state, S_FETCH);
        cyc(0, 0, 0);
        check("b_c2_state", state, S_DECODE);
        cyc(0, 0, 0);
        check("b_c3_state", state, S_B_BR);
        check("b_c3_imm_sel", imm_sel, 2'b00);
        check("b_c3_pc_src", pc_src, 2'b01);
        check("b_c3_pc_write", pc_write, 1);
        cyc(0, 0, 0);
        check("b_done_state", state, S_FETCH);
        check("b_done_retired", retired, 5);

        // Illegal opcode traps for one cycle, not retired
        instr = I_ILL;
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        cyc(0, 0, 0);
        check("ill_c2_state", state, S_DECODE);
        check("ill_c2_illegal_op", illegal_op, 1);
        cyc(0, 0, 0);
        check("ill_c3_state", state, S_FETCH);
        check("ill_c3_illegal_op", illegal_op, 0);
        check("ill_c3_retired", retired, 5);

        // STUR with a fetch wait, ready arriving with the first write request
        instr = I_STUR;
        cyc(0, 1, 0);
        check("stur_wait_state", state, S_FETCH);
        check("stur_wait_pc_write", pc_write, 0);
        check("stur_wait_dmem_wr", dmem_wr, 0);
        cyc(1, 0, 0);
        check("stur_c1_ir_write", ir_write, 1);
        cyc(0, 0, 0);
        check("stur_c2_state", state, S_DECODE);
        cyc(0, 0, 0);
        check("stur_c3_state", state, S_EX_ADDR);
        cyc(0, 1, 0);
        check("stur_c4_state", state, S_MEM_WR);
        check("stur_c4_dmem_wr", dmem_wr, 1);
        check("stur_c4_reg2loc", reg2loc, 1);
        check("stur_c4_reg_write", reg_write, 0);
        cyc(0, 0, 0);
        check("stur_done_state", state, S_FETCH);
        check("stur_done_retired", retired, 6);

        // STUR aborted by reset during MEM_WR
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("abort_pre_state", state, S_MEM_WR);
        check("abort_pre_dmem_wr", dmem_wr, 1);
        rst_n = 1'b0;
        cyc(0, 0, 0);
        check("abort_state", state, S_FETCH);
        check("abort_dmem_wr", dmem_wr, 0);
        check("abort_retired", retired, 0);
        check("abort_imem_req_in_rst", imem_req, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0);
        check("abort_imem_req_after", imem_req, 1);
        check("abort_state_after", state, S_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/legv8_mc_ctrl.md
Name: legv8_mc_ctrl

Overview:
- Multi-cycle control FSM for the LEGv8 CPU datapath.
- Sequences fetch, decode, execute, memory and writeback phases for R-type (ADD, SUB, AND, ORR), LDUR, STUR, CBZ and B.
- Drives the immediate-format select of the sign-extend unit, ALU/mux selects, register-file write and memory requests.
- Waits on ready handshakes from instruction and data memory, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TRAP_ON_ILLEGAL, 1, 1 = pulse illegal_op and skip undecodable opcodes; 0 = treat them as NOP (no trap pulse).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- instr  input  32  instruction word from imem, valid when imem_ready=1.
- zero  input  1  ALU zero flag, combinational from the datapath.
- imem_ready  input  1  imem read data valid this cycle.
- dmem_ready  input  1  dmem access completes this cycle.
- imem_req  output  1  instruction fetch request.
- dmem_rd  output  1  data read request.
- dmem_wr  output  1  data write request.
- ir_write  output  1  latch instr into IR and PC into old_pc.
- pc_write  output  1  update PC.
- pc_src  output  2  00 = PC+4, 01 = old_pc + (imm<<2).
- imm_sel  output  2  sign-extend format: 00 = B imm26, 01 = CB imm19, 10 = D imm9.
- reg2loc  output  1  1 = read-port-2 address from Rt (STUR, CBZ).
- alu_src  output  1  1 = ALU B operand is the immediate.
- alu_op  output  2  00 = add, 01 = pass B, 10 = R-type funct decode.
- reg_write  output  1  regfile write enable.
- mem_to_reg  output  1  1 = writeback from dmem.
- illegal_op  output  1  one-cycle pulse on an undecodable opcode.
- retired  output  CNT_W  retired-instruction count.
- state  output  4  current state, for debug.

Behaviour:
- Reset: state=FETCH and retired=0. All outputs are 0 except imem_req, which is 1 from the first cycle after reset is released. Reset asserted mid-operation aborts any pending request on the next clock edge with no partial writes.
- Outputs are Moore, decoded from the state register. The exceptions are pc_write in FETCH and CB_BR, and the memory-completion strobes, which are gated by inputs as listed below.
- FETCH: imem_req=1. When imem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise stay in FETCH.
- DECODE: classify IR[31:21] and hold IR internally.
  - 10001011000 / 11001011000 / 10001010000 / 10101010000 -> EX_R.
  - 11111000010 (LDUR) and 11111000000 (STUR) -> EX_ADDR.
  - IR[31:24]=10110100 (CBZ) -> CB_BR.
  - IR[31:26]=000101 (B) -> B_BR.
  - Any other opcode -> FETCH. illegal_op=1 for that cycle if TRAP_ON_ILLEGAL=1. Not counted as retired.
- EX_R: alu_src=0, alu_op=10 -> WB_R.
- WB_R: reg_write=1, mem_to_reg=0, retired+1 -> FETCH.
- EX_ADDR: imm_sel=10, alu_src=1, alu_op=00, reg2loc=1. Go to MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: dmem_rd=1, imm_sel/alu controls held. On dmem_ready -> WB_LD.
- WB_LD: reg_write=1, mem_to_reg=1, retired+1 -> FETCH.
- MEM_WR: dmem_wr=1, reg2loc=1, controls held. On dmem_ready: retired+1 -> FETCH.
- CB_BR: reg2loc=1, alu_op=01, imm_sel=01, pc_src=01, pc_write=zero, retired+1 -> FETCH.
- B_BR: imm_sel=00, pc_src=01, pc_write=1, retired+1 -> FETCH.
- Requests stay asserted until ready. A ready seen while no request is asserted is ignored. Ready may arrive in the same cycle as the request is first asserted.
- Zero-wait cycle counts, FETCH through completion: R = 4, LDUR = 5, STUR = 4, CBZ = 3, B = 3. Each wait cycle adds one.
- retired wraps modulo 2^CNT_W with no flag.
- The 4-bit state encoding is shared with the bench.

Decomposition:
- Package legv8_pkg holds:
  - state enum;
  - opcode constants (OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ8, OP_B6);
  - imm_sel constants IMM_B, IMM_CB, IMM_D;
  - alu_op and pc_src constants.
- One sub-module, legv8_opdecode: combinational, maps IR[31:21] to an instruction class and an illegal flag. The FSM lives in legv8_mc_ctrl.

Test Plan:
- ADD X0,X1,X2 (0x8B020020), imem_ready=1 immediately -> states FETCH, DECODE, EX_R, WB_R. reg_write=1 in cycle 4, alu_op=10. retired 0->1.
- LDUR X0,[X1,#8] (0xF8408020), dmem_ready delayed 3 cycles -> dmem_rd held 4 cycles with imm_sel=10 and alu_src=1, then WB_LD with mem_to_reg=1. 8 cycles total.
- CBZ X3,#4 (0xB4000083): zero=1 -> pc_write=1, pc_src=01, imm_sel=01 in cycle 3. Repeat with zero=0 -> pc_write=0 in cycle 3. retired increments both times.
- B #-1 (0x17FFFFFF) -> imm_sel=00, pc_src=01, pc_write=1 in cycle 3, then FETCH.
- Illegal 0x00000000 with TRAP_ON_ILLEGAL=1 -> illegal_op pulses 1 cycle in DECODE, back to FETCH, retired unchanged.
- STUR with rst_n driven low during MEM_WR -> dmem_wr=0 and state=FETCH after the next edge, retired=0, imem_req=1 the cycle after rst_n returns high.
